// File: rtl/alpha_ram_pingpong_pkg.sv
// Shared types and helpers for the ping-pong alpha store.
package alpha_pkg;

  localparam int ALPHA_W_DEF = 8;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } alpha_st_t;

  function automatic int unsigned next_bank(input int unsigned idx, input int unsigned num_bank);
    int unsigned nxt_s;
    if (idx + 32'd1 >= num_bank) begin
      nxt_s = 32'd0;
    end else begin
      nxt_s = idx + 32'd1;
    end
    return nxt_s;
  endfunction

endpackage

// File: rtl/alpha_ram_pingpong_ram.sv
// Simple 1R1W RAM with a registered read port; read data holds when re is low.
module ram #(
  parameter int addr_width = 3,
  parameter int mem_width  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [addr_width-1:0] waddr,
  input  logic [mem_width-1:0]  wdata,
  input  logic                  re,
  input  logic [addr_width-1:0] raddr,
  output logic [mem_width-1:0]  rdata
);

  logic [mem_width-1:0] mem_q [2**addr_width];
  logic [mem_width-1:0] rdata_q;

  // storage array write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // registered read port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= {mem_width{1'b0}};
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end else begin
      rdata_q <= rdata_q;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/alpha_ram_pingpong.sv
// Banked ping-pong alpha store: reads come from rd_bank, writes go to the next bank,
// and an init sweep loads |0...0> into every bank after reset or on request.
module alpha_ram_pingpong
  import alpha_pkg::*;
#(
  parameter int         NUM_QUBIT = 3,
  parameter int         ALPHA_W   = ALPHA_W_DEF,
  parameter int         NUM_BANK  = 2,
  parameter logic [7:0] INIT_ONE  = 8'h01,
  localparam int        BANK_W    = $clog2(NUM_BANK)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 init_req,
  output logic                 busy,
  input  logic                 swap,
  output logic [BANK_W-1:0]    rd_bank,
  input  logic                 rd_en,
  input  logic [NUM_QUBIT-1:0] rd_addr,
  output logic [ALPHA_W-1:0]   rd_data,
  output logic                 rd_valid,
  input  logic                 wr_en,
  input  logic [NUM_QUBIT-1:0] wr_addr,
  input  logic [ALPHA_W-1:0]   wr_data,
  output logic                 err
);

  localparam logic [ALPHA_W-1:0]   INIT_VAL  = ALPHA_W'(INIT_ONE);
  localparam logic [NUM_QUBIT-1:0] LAST_ADDR = {NUM_QUBIT{1'b1}};

  alpha_st_t            state_q, state_d;
  logic [NUM_QUBIT-1:0] sweep_addr_q, sweep_addr_d;
  logic                 busy_q, busy_d;
  logic [BANK_W-1:0]    rd_bank_q, rd_bank_d;
  logic [BANK_W-1:0]    rd_sel_q, rd_sel_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 err_q, err_d;
  logic [BANK_W-1:0]    wr_bank_s;
  logic                 rd_acc_s, wr_acc_s, swap_acc_s, init_wr_s;
  logic [ALPHA_W-1:0]   init_data_s;
  logic [ALPHA_W-1:0]   bank_rdata_s [NUM_BANK];

  // request qualification, bank rotation and sweep write data
  always_comb begin
    rd_acc_s   = rd_en & ~busy_q;
    wr_acc_s   = wr_en & ~busy_q;
    swap_acc_s = swap & ~busy_q;
    wr_bank_s  = BANK_W'(next_bank(32'(rd_bank_q), 32'(NUM_BANK)));
    init_wr_s  = (state_q == ST_INIT);
    if (sweep_addr_q == {NUM_QUBIT{1'b0}}) begin
      init_data_s = INIT_VAL;
    end else begin
      init_data_s = {ALPHA_W{1'b0}};
    end
  end

  // init FSM next state; init_req always restarts the sweep from address 0
  always_comb begin
    state_d      = state_q;
    sweep_addr_d = sweep_addr_q;
    case (state_q)
      ST_INIT: begin
        if (init_req) begin
          sweep_addr_d = {NUM_QUBIT{1'b0}};
        end else if (sweep_addr_q == LAST_ADDR) begin
          state_d      = ST_READY;
          sweep_addr_d = {NUM_QUBIT{1'b0}};
        end else begin
          sweep_addr_d = sweep_addr_q + NUM_QUBIT'(1);
        end
      end
      ST_READY: begin
        if (init_req) begin
          state_d      = ST_INIT;
          sweep_addr_d = {NUM_QUBIT{1'b0}};
        end else begin
          state_d      = ST_READY;
        end
      end
      default: begin
        state_d      = ST_INIT;
        sweep_addr_d = {NUM_QUBIT{1'b0}};
      end
    endcase
    busy_d = (state_d == ST_INIT);
  end

  // bank pointer, read qualifier and sticky error next state
  always_comb begin
    if (swap_acc_s) begin
      rd_bank_d = wr_bank_s;
    end else begin
      rd_bank_d = rd_bank_q;
    end
    if (rd_acc_s) begin
      rd_sel_d = rd_bank_q;
    end else begin
      rd_sel_d = rd_sel_q;
    end
    rd_valid_d = rd_acc_s;
    err_d      = err_q | (busy_q & (rd_en | wr_en | swap));
  end

  // control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      sweep_addr_q <= {NUM_QUBIT{1'b0}};
      busy_q       <= 1'b1;
      rd_bank_q    <= {BANK_W{1'b0}};
      rd_sel_q     <= {BANK_W{1'b0}};
      rd_valid_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_addr_q <= sweep_addr_d;
      busy_q       <= busy_d;
      rd_bank_q    <= rd_bank_d;
      rd_sel_q     <= rd_sel_d;
      rd_valid_q   <= rd_valid_d;
      err_q        <= err_d;
    end
  end

  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    logic                 we_s;
    logic [NUM_QUBIT-1:0] waddr_s;
    logic [ALPHA_W-1:0]   wdata_s;

    // the sweep owns every bank's write port while it runs
    always_comb begin
      if (init_wr_s) begin
        we_s    = 1'b1;
        waddr_s = sweep_addr_q;
        wdata_s = init_data_s;
      end else begin
        we_s    = wr_acc_s & (wr_bank_s == BANK_W'(b));
        waddr_s = wr_addr;
        wdata_s = wr_data;
      end
    end

    ram #(
      .addr_width(NUM_QUBIT),
      .mem_width (ALPHA_W)
    ) u_ram (
      .clk  (clk),
      .rst_n(rst_n),
      .we   (we_s),
      .waddr(waddr_s),
      .wdata(wdata_s),
      .re   (rd_acc_s),
      .raddr(rd_addr),
      .rdata(bank_rdata_s[b])
    );
  end

  assign busy     = busy_q;
  assign rd_bank  = rd_bank_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = bank_rdata_s[rd_sel_q];
  assign err      = err_q;

endmodule

// File: tb/tb_alpha_ram_pingpong.sv
// Directed bench: a 2-bank instance for most scenarios, a 3-bank instance for rotation.
module tb_alpha_ram_pingpong;

  logic       clk = 1'b0;
  logic       rst_n;
  int         errors = 0;
  int         checks = 0;

  logic       a_init_req = 1'b0, a_swap = 1'b0, a_rd_en = 1'b0, a_wr_en = 1'b0;
  logic [2:0] a_rd_addr = 3'd0, a_wr_addr = 3'd0;
  logic [7:0] a_wr_data = 8'h00;
  logic       a_busy, a_rd_valid, a_err;
  logic [0:0] a_rd_bank;
  logic [7:0] a_rd_data;

  logic       b_init_req = 1'b0, b_swap = 1'b0, b_rd_en = 1'b0, b_wr_en = 1'b0;
  logic [2:0] b_rd_addr = 3'd0, b_wr_addr = 3'd0;
  logic [7:0] b_wr_data = 8'h00;
  logic       b_busy, b_rd_valid, b_err;
  logic [1:0] b_rd_bank;
  logic [7:0] b_rd_data;

  always #5 clk = ~clk;

  alpha_ram_pingpong u_dut2 (
    .clk(clk), .rst_n(rst_n), .init_req(a_init_req), .busy(a_busy), .swap(a_swap),
    .rd_bank(a_rd_bank), .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
    .rd_valid(a_rd_valid), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .err(a_err)
  );

  alpha_ram_pingpong #(.NUM_BANK(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .init_req(b_init_req), .busy(b_busy), .swap(b_swap),
    .rd_bank(b_rd_bank), .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .rd_valid(b_rd_valid), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .err(b_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd2(input logic [2:0] a, input logic [7:0] exp, input string tag);
    a_rd_en = 1'b1; a_rd_addr = a;
    tick();
    a_rd_en = 1'b0;
    chk({tag, "_v"}, 32'(a_rd_valid), 32'd1);
    chk({tag, "_d"}, 32'(a_rd_data), 32'(exp));
  endtask

  task automatic rd3(input logic [2:0] a, input logic [7:0] exp, input string tag);
    b_rd_en = 1'b1; b_rd_addr = a;
    tick();
    b_rd_en = 1'b0;
    chk({tag, "_v"}, 32'(b_rd_valid), 32'd1);
    chk({tag, "_d"}, 32'(b_rd_data), 32'(exp));
  endtask

  task automatic wr2(input logic [2:0] a, input logic [7:0] d);
    a_wr_en = 1'b1; a_wr_addr = a; a_wr_data = d;
    tick();
    a_wr_en = 1'b0;
  endtask

  task automatic sw2(input logic [31:0] exp_bank, input string tag);
    a_swap = 1'b1;
    tick();
    a_swap = 1'b0;
    chk(tag, 32'(a_rd_bank), exp_bank);
  endtask

  task automatic sweep_wait(input string tag);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("%s_busy%0d", tag, i), 32'(a_busy), (i < 8) ? 32'd1 : 32'd0);
    end
  endtask

  int unsigned exp_seq [3] = '{32'd1, 32'd2, 32'd0};

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    // reset state
    chk("rst_busy", 32'(a_busy), 32'd1);
    chk("rst_valid", 32'(a_rd_valid), 32'd0);
    chk("rst_data", 32'(a_rd_data), 32'd0);
    chk("rst_err", 32'(a_err), 32'd0);
    chk("rst_bank", 32'(a_rd_bank), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // 1: sweep after release, both banks hold |0>
    sweep_wait("t1");
    chk("t1_b3_busy", 32'(b_busy), 32'd0);
    for (int i = 0; i < 8; i++) rd2(3'(i), (i == 0) ? 8'h01 : 8'h00, $sformatf("t1_b0_a%0d", i));
    tick();
    chk("t1_valid_drop", 32'(a_rd_valid), 32'd0);
    sw2(32'd1, "t1_swap1");
    for (int i = 0; i < 8; i++) rd2(3'(i), (i == 0) ? 8'h01 : 8'h00, $sformatf("t1_b1_a%0d", i));
    sw2(32'd0, "t1_swap0");

    // 3: three-bank rotation, writes land in banks 1,2,0
    for (int k = 0; k < 3; k++) begin
      b_wr_en = 1'b1; b_wr_addr = 3'd1; b_wr_data = 8'h10 + 8'(k);
      tick();
      b_wr_en = 1'b0; b_swap = 1'b1;
      tick();
      b_swap = 1'b0;
      chk($sformatf("t3_bank%0d", k), 32'(b_rd_bank), exp_seq[k]);
    end
    rd3(3'd1, 8'h12, "t3_b0");
    b_swap = 1'b1; tick(); b_swap = 1'b0;
    rd3(3'd1, 8'h10, "t3_b1");
    b_swap = 1'b1; tick(); b_swap = 1'b0;
    rd3(3'd1, 8'h11, "t3_b2");
    rd3(3'd0, 8'h01, "t3_b2_a0");

    // 2: write goes to the bank not being read
    wr2(3'd5, 8'hA5);
    rd2(3'd5, 8'h00, "t2_pre");
    tick();
    chk("t2_pulse", 32'(a_rd_valid), 32'd0);
    sw2(32'd1, "t2_swap");
    rd2(3'd5, 8'hA5, "t2_post");
    tick();
    chk("t2_pulse2", 32'(a_rd_valid), 32'd0);
    chk("t2_hold", 32'(a_rd_data), 32'hA5);

    // 4: read, write and swap together use the old mapping
    wr2(3'd2, 8'h77);
    sw2(32'd0, "t4_swap0");
    a_rd_en = 1'b1; a_rd_addr = 3'd2;
    a_wr_en = 1'b1; a_wr_addr = 3'd2; a_wr_data = 8'h3C;
    a_swap  = 1'b1;
    tick();
    a_rd_en = 1'b0; a_wr_en = 1'b0; a_swap = 1'b0;
    chk("t4_valid", 32'(a_rd_valid), 32'd1);
    chk("t4_old", 32'(a_rd_data), 32'h77);
    chk("t4_bank", 32'(a_rd_bank), 32'd1);
    rd2(3'd2, 8'h3C, "t4_new");
    chk("t4_err", 32'(a_err), 32'd0);

    // 5: restart mid-sweep, requests while busy are dropped and flagged
    a_init_req = 1'b1;
    tick();
    a_init_req = 1'b0;
    chk("t5_busy_start", 32'(a_busy), 32'd1);
    repeat (4) tick();
    a_init_req = 1'b1; a_wr_en = 1'b1; a_wr_addr = 3'd3; a_wr_data = 8'hFF; a_swap = 1'b1;
    tick();
    a_init_req = 1'b0; a_wr_en = 1'b0; a_swap = 1'b0;
    chk("t5_err", 32'(a_err), 32'd1);
    chk("t5_bank_kept", 32'(a_rd_bank), 32'd1);
    sweep_wait("t5");
    for (int i = 0; i < 8; i++) rd2(3'(i), (i == 0) ? 8'h01 : 8'h00, $sformatf("t5_b1_a%0d", i));
    sw2(32'd0, "t5_swap0");
    for (int i = 0; i < 8; i++) rd2(3'(i), (i == 0) ? 8'h01 : 8'h00, $sformatf("t5_b0_a%0d", i));
    chk("t5_err_sticky", 32'(a_err), 32'd1);

    // 6: async reset during a sweep with a read in flight
    sw2(32'd1, "t6_swap1");
    a_init_req = 1'b1; a_rd_en = 1'b1; a_rd_addr = 3'd0;
    tick();
    a_init_req = 1'b0; a_rd_en = 1'b0;
    chk("t6_pre_valid", 32'(a_rd_valid), 32'd1);
    chk("t6_pre_data", 32'(a_rd_data), 32'h01);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_valid", 32'(a_rd_valid), 32'd0);
    chk("t6_data", 32'(a_rd_data), 32'd0);
    chk("t6_err", 32'(a_err), 32'd0);
    chk("t6_bank", 32'(a_rd_bank), 32'd0);
    chk("t6_busy", 32'(a_busy), 32'd1);
    tick();
    rst_n = 1'b1;
    sweep_wait("t6");
    chk("t6_bank_after", 32'(a_rd_bank), 32'd0);
    rd2(3'd0, 8'h01, "t6_rd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
